// File: rtl/mem_access_ctrl_if.sv
// Bus-side and SRAM-side signal bundle for the MAR/MDR memory-access unit.
// The controller connects through the slave modport; the bus/SRAM environment
// connects through the master modport.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic [DATA_W-1:0] BUS;
    logic              LD_MAR;
    logic              LD_MDR;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] Data_from_SRAM;
    logic [DATA_W-1:0] MAR;
    logic [DATA_W-1:0] MDR;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [DATA_W-1:0] Data_to_SRAM;
    logic              data_oe;
    logic              CE_N;
    logic              OE_N;
    logic              WE_N;
    logic              R;
    logic              busy;
    logic              busy_err;

    modport master (
        output BUS, LD_MAR, LD_MDR, mem_req, mem_we, Data_from_SRAM,
        input  MAR, MDR, SRAM_ADDR, Data_to_SRAM, data_oe,
        input  CE_N, OE_N, WE_N, R, busy, busy_err
    );

    modport slave (
        input  BUS, LD_MAR, LD_MDR, mem_req, mem_we, Data_from_SRAM,
        output MAR, MDR, SRAM_ADDR, Data_to_SRAM, data_oe,
        output CE_N, OE_N, WE_N, R, busy, busy_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory-access unit: holds MAR and MDR and sequences wait-stated
// SRAM reads and writes, returning a one-cycle ready pulse (R) on completion.
module mem_access_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input logic             Clk,
    input logic             Reset_ah,
    mem_access_ctrl_if.slave io
);
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic              busy_err_q;
    logic              any_cmd;
    logic              in_access;

    assign any_cmd   = io.LD_MAR | io.LD_MDR | io.mem_req;
    assign in_access = (state == RD) || (state == WR_SETUP) ||
                       (state == WR_PULSE) || (state == WR_HOLD);

    // Sequencer: register loads, access state, wait counter and busy_err flag.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            state      <= IDLE;
            cnt        <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            busy_err_q <= 1'b0;
        end else begin
            // Commands arriving mid-access are dropped but flagged next cycle.
            busy_err_q <= in_access & any_cmd;
            case (state)
                IDLE: begin
                    if (io.LD_MAR) mar_q <= io.BUS;
                    if (io.LD_MDR) mdr_q <= io.BUS;
                    if (io.mem_req) begin
                        if (io.mem_we) begin
                            state <= WR_SETUP;
                        end else begin
                            state <= RD;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                RD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mdr_q <= io.Data_from_SRAM;
                        state <= DONE;
                    end
                end
                WR_SETUP: begin
                    state <= WR_PULSE;
                    cnt   <= CNT_INIT;
                end
                WR_PULSE: begin
                    if (cnt != 4'd0) cnt   <= cnt - 4'd1;
                    else             state <= WR_HOLD;
                end
                WR_HOLD: state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes and status decode from state alone so reset releases them at once.
    always_comb begin
        io.CE_N    = 1'b1;
        io.OE_N    = 1'b1;
        io.WE_N    = 1'b1;
        io.data_oe = 1'b0;
        io.R       = 1'b0;
        io.busy    = (state != IDLE);
        case (state)
            RD: begin
                io.CE_N = 1'b0;
                io.OE_N = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                io.CE_N    = 1'b0;
                io.data_oe = 1'b1;
            end
            WR_PULSE: begin
                io.CE_N    = 1'b0;
                io.WE_N    = 1'b0;
                io.data_oe = 1'b1;
            end
            DONE:    io.R = 1'b1;
            default: ;
        endcase
    end

    assign io.MAR          = mar_q;
    assign io.MDR          = mdr_q;
    assign io.SRAM_ADDR    = ADDR_W'(mar_q);
    assign io.Data_to_SRAM = mdr_q;
    assign io.busy_err     = busy_err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: one unit with two wait states and one with none,
// each attached to its own SRAM model, checked every cycle against a
// schedule-based model plus hand-computed expectations.
module tb_mem_access_ctrl;
    logic Clk;
    logic Reset_ah;
    logic armed;

    int n_chk;
    int n_fail;

    // Per-unit stimulus and observed outputs (index 0: 2 wait states, 1: none).
    logic [15:0] bus [2];
    logic        ld_mar [2];
    logic        ld_mdr [2];
    logic        req [2];
    logic        we [2];
    logic [15:0] dfs [2];
    logic [15:0] mar_o [2];
    logic [15:0] mdr_o [2];
    logic [19:0] addr_o [2];
    logic [15:0] dto_o [2];
    logic        doe_o [2];
    logic        ce_o [2];
    logic        oe_o [2];
    logic        wen_o [2];
    logic        r_o [2];
    logic        busy_o [2];
    logic        berr_o [2];

    int wc [2] = '{2, 0};

    // SRAM contents per unit.
    logic [15:0] mem0 [int];
    logic [15:0] mem1 [int];

    // Model state: access kind (0 none, 1 read, 2 write) and cycles since accept.
    logic [15:0] m_mar [2];
    logic [15:0] m_mdr [2];
    int          m_kind [2];
    int          m_el [2];
    logic        m_berr [2];

    mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(20)) ifc0 ();
    mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(20)) ifc1 ();

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_CYCLES(2)) dut0 (
        .Clk(Clk), .Reset_ah(Reset_ah), .io(ifc0)
    );
    mem_access_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_CYCLES(0)) dut1 (
        .Clk(Clk), .Reset_ah(Reset_ah), .io(ifc1)
    );

    assign ifc0.BUS = bus[0];
    assign ifc0.LD_MAR = ld_mar[0];
    assign ifc0.LD_MDR = ld_mdr[0];
    assign ifc0.mem_req = req[0];
    assign ifc0.mem_we = we[0];
    assign ifc0.Data_from_SRAM = dfs[0];
    assign ifc1.BUS = bus[1];
    assign ifc1.LD_MAR = ld_mar[1];
    assign ifc1.LD_MDR = ld_mdr[1];
    assign ifc1.mem_req = req[1];
    assign ifc1.mem_we = we[1];
    assign ifc1.Data_from_SRAM = dfs[1];

    assign mar_o[0] = ifc0.MAR;
    assign mdr_o[0] = ifc0.MDR;
    assign addr_o[0] = ifc0.SRAM_ADDR;
    assign dto_o[0] = ifc0.Data_to_SRAM;
    assign doe_o[0] = ifc0.data_oe;
    assign ce_o[0] = ifc0.CE_N;
    assign oe_o[0] = ifc0.OE_N;
    assign wen_o[0] = ifc0.WE_N;
    assign r_o[0] = ifc0.R;
    assign busy_o[0] = ifc0.busy;
    assign berr_o[0] = ifc0.busy_err;
    assign mar_o[1] = ifc1.MAR;
    assign mdr_o[1] = ifc1.MDR;
    assign addr_o[1] = ifc1.SRAM_ADDR;
    assign dto_o[1] = ifc1.Data_to_SRAM;
    assign doe_o[1] = ifc1.data_oe;
    assign ce_o[1] = ifc1.CE_N;
    assign oe_o[1] = ifc1.OE_N;
    assign wen_o[1] = ifc1.WE_N;
    assign r_o[1] = ifc1.R;
    assign busy_o[1] = ifc1.busy;
    assign berr_o[1] = ifc1.busy_err;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sram_rd(input int d, input logic [19:0] a);
        int ai;
        logic [15:0] dflt;
        ai = int'(a);
        dflt = {a[7:0], ~a[7:0]};
        if (d == 0) return mem0.exists(ai) ? mem0[ai] : dflt;
        return mem1.exists(ai) ? mem1[ai] : dflt;
    endfunction

    function automatic int total_of(input int kind, input int w);
        return (kind == 1) ? w + 1 : w + 3;
    endfunction

    // SRAM read port: address is stable from the previous rising edge.
    always @(negedge Clk) begin
        for (int d = 0; d < 2; d++) dfs[d] = sram_rd(d, addr_o[d]);
    end

    // SRAM write takes place at the end of the WE_N pulse.
    always @(posedge ifc0.WE_N) begin
        if (!Reset_ah && !$isunknown(ifc0.SRAM_ADDR))
            mem0[int'(ifc0.SRAM_ADDR)] = ifc0.Data_to_SRAM;
    end
    always @(posedge ifc1.WE_N) begin
        if (!Reset_ah && !$isunknown(ifc1.SRAM_ADDR))
            mem1[int'(ifc1.SRAM_ADDR)] = ifc1.Data_to_SRAM;
    end

    // Model: an accepted access lasts a fixed number of busy cycles, then one
    // ready cycle; commands during the busy cycles are dropped and flagged.
    always @(posedge Clk or posedge Reset_ah) begin
        for (int d = 0; d < 2; d++) begin
            if (Reset_ah) begin
                m_mar[d] <= '0;
                m_mdr[d] <= '0;
                m_kind[d] <= 0;
                m_el[d] <= 0;
                m_berr[d] <= 1'b0;
            end else if (m_kind[d] == 0) begin
                m_berr[d] <= 1'b0;
                if (ld_mar[d]) m_mar[d] <= bus[d];
                if (ld_mdr[d]) m_mdr[d] <= bus[d];
                if (req[d]) begin
                    m_kind[d] <= we[d] ? 2 : 1;
                    m_el[d] <= 0;
                end
            end else if (m_el[d] == total_of(m_kind[d], wc[d])) begin
                m_kind[d] <= 0;
                m_berr[d] <= 1'b0;
            end else begin
                m_berr[d] <= ld_mar[d] | ld_mdr[d] | req[d];
                if (m_kind[d] == 1 && m_el[d] == wc[d]) m_mdr[d] <= sram_rd(d, {4'h0, m_mar[d]});
                m_el[d] <= m_el[d] + 1;
            end
        end
    end

    // Per-cycle comparison of both units against the model.
    always @(negedge Clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                automatic int  tot = total_of(m_kind[d], wc[d]);
                automatic bit  act = (m_kind[d] != 0) && (m_el[d] < tot);
                automatic bit  rdp = act && (m_kind[d] == 1);
                automatic bit  wrp = act && (m_kind[d] == 2);
                automatic bit  wel = wrp && (m_el[d] >= 1) && (m_el[d] <= wc[d] + 1);
                chk($sformatf("d%0d MAR", d), mar_o[d], m_mar[d]);
                chk($sformatf("d%0d MDR", d), mdr_o[d], m_mdr[d]);
                chk($sformatf("d%0d SRAM_ADDR", d), addr_o[d], {4'h0, m_mar[d]});
                chk($sformatf("d%0d Data_to_SRAM", d), dto_o[d], m_mdr[d]);
                chk($sformatf("d%0d data_oe", d), doe_o[d], wrp);
                chk($sformatf("d%0d CE_N", d), ce_o[d], !act);
                chk($sformatf("d%0d OE_N", d), oe_o[d], !rdp);
                chk($sformatf("d%0d WE_N", d), wen_o[d], !wel);
                chk($sformatf("d%0d R", d), r_o[d], (m_kind[d] != 0) && (m_el[d] == tot));
                chk($sformatf("d%0d busy", d), busy_o[d], m_kind[d] != 0);
                chk($sformatf("d%0d busy_err", d), berr_o[d], m_berr[d]);
            end
        end
    end

    task automatic ld(input int d, input bit to_mar, input logic [15:0] v);
        @(negedge Clk);
        bus[d] = v;
        if (to_mar) ld_mar[d] = 1'b1;
        else        ld_mdr[d] = 1'b1;
        @(negedge Clk);
        ld_mar[d] = 1'b0;
        ld_mdr[d] = 1'b0;
    endtask

    // Issue one access (optionally loading MAR on the same edge) and wait for R.
    task automatic access(input int d, input bit wr, input bit do_ld, input logic [15:0] v,
                          output int edges, output int oe_lo, output int we_lo, output int berr_n);
        edges = 0; oe_lo = 0; we_lo = 0; berr_n = 0;
        @(negedge Clk);
        req[d] = 1'b1;
        we[d] = wr;
        if (do_ld) begin
            bus[d] = v;
            ld_mar[d] = 1'b1;
        end
        @(negedge Clk);
        req[d] = 1'b0;
        we[d] = 1'b0;
        ld_mar[d] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            berr_n += int'(berr_o[d]);
            if (r_o[d]) break;
            oe_lo += int'(!oe_o[d]);
            we_lo += int'(!wen_o[d]);
            @(negedge Clk);
            edges++;
        end
        if (!r_o[d]) begin
            n_chk++;
            n_fail++;
            $display("FAIL d%0d ready timeout: R=%0b after %0d edges, required 1", d, r_o[d], edges);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1);
    end

    initial begin
        int e, ol, wl, be;
        n_chk = 0;
        n_fail = 0;
        armed = 1'b0;
        Reset_ah = 1'b0;
        for (int d = 0; d < 2; d++) begin
            bus[d] = '0; ld_mar[d] = 0; ld_mdr[d] = 0; req[d] = 0; we[d] = 0;
            m_mar[d] = '0; m_mdr[d] = '0; m_kind[d] = 0; m_el[d] = 0; m_berr[d] = 0;
        end
        mem0[32'h3000] = 16'hABCD;
        mem1[32'h3000] = 16'hABCD;
        #2 Reset_ah = 1'b1;
        armed = 1'b1;
        repeat (3) @(negedge Clk);
        Reset_ah = 1'b0;

        // Reset state held through idle cycles.
        repeat (5) @(negedge Clk);
        chk("reset MAR", mar_o[0], 16'h0000);
        chk("reset MDR", mdr_o[0], 16'h0000);
        chk("reset CE_N", ce_o[0], 1'b1);
        chk("reset OE_N", oe_o[0], 1'b1);
        chk("reset WE_N", wen_o[0], 1'b1);
        chk("reset R", r_o[0], 1'b0);
        chk("reset busy", busy_o[0], 1'b0);

        // Read with two wait states.
        ld(0, 1'b1, 16'h3000);
        access(0, 1'b0, 1'b0, 16'h0000, e, ol, wl, be);
        chk("rd edges to R", e, 3);
        chk("rd OE_N low cycles", ol, 3);
        chk("rd WE_N low cycles", wl, 0);
        chk("rd MDR", mdr_o[0], 16'hABCD);
        chk("rd SRAM_ADDR", addr_o[0], 20'h03000);

        // Write: MDR loaded, then MAR load and request on the same edge.
        ld(0, 1'b0, 16'h1234);
        access(0, 1'b1, 1'b1, 16'h0042, e, ol, wl, be);
        chk("wr edges to R", e, 5);
        chk("wr WE_N low cycles", wl, 3);
        chk("wr OE_N low cycles", ol, 0);
        chk("wr MAR", mar_o[0], 16'h0042);
        chk("wr mem[0x42]", mem0.exists(32'h42) ? {16'h0, mem0[32'h42]} : 32'hFFFF_FFFF, 32'h1234);

        // LD_MAR during a read is dropped and flagged for one cycle.
        @(negedge Clk);
        req[0] = 1'b1;
        @(negedge Clk);
        req[0] = 1'b0;
        bus[0] = 16'hFFFF;
        ld_mar[0] = 1'b1;
        @(negedge Clk);
        ld_mar[0] = 1'b0;
        chk("busy_err pulse", berr_o[0], 1'b1);
        @(negedge Clk);
        chk("busy_err clears", berr_o[0], 1'b0);
        @(negedge Clk);
        chk("busy rd R", r_o[0], 1'b1);
        chk("busy rd MAR held", mar_o[0], 16'h0042);
        chk("busy rd MDR", mdr_o[0], 16'h1234);

        // Reset asserted mid-cycle inside the write pulse.
        @(negedge Clk);
        req[0] = 1'b1;
        we[0] = 1'b1;
        @(negedge Clk);
        req[0] = 1'b0;
        we[0] = 1'b0;
        @(negedge Clk);
        chk("pre-reset WE_N", wen_o[0], 1'b0);
        #2 Reset_ah = 1'b1;
        #1;
        chk("async rst WE_N", wen_o[0], 1'b1);
        chk("async rst CE_N", ce_o[0], 1'b1);
        chk("async rst busy", busy_o[0], 1'b0);
        chk("async rst data_oe", doe_o[0], 1'b0);
        chk("async rst MAR", mar_o[0], 16'h0000);
        chk("async rst MDR", mdr_o[0], 16'h0000);
        @(negedge Clk);
        Reset_ah = 1'b0;

        // No wait states: read, then back-to-back write and read.
        ld(1, 1'b1, 16'h3000);
        access(1, 1'b0, 1'b0, 16'h0000, e, ol, wl, be);
        chk("w0 rd edges to R", e, 1);
        chk("w0 rd OE_N low cycles", ol, 1);
        chk("w0 rd MDR", mdr_o[1], 16'hABCD);
        chk("w0 rd busy_err", be, 0);
        access(1, 1'b1, 1'b1, 16'h0100, e, ol, wl, be);
        chk("w0 wr edges to R", e, 3);
        chk("w0 wr WE_N low cycles", wl, 1);
        chk("w0 wr busy_err", be, 0);
        access(1, 1'b0, 1'b0, 16'h0000, e, ol, wl, be);
        chk("w0 rd2 edges to R", e, 1);
        chk("w0 rd2 MDR", mdr_o[1], 16'hABCD);
        chk("w0 rd2 busy_err", be, 0);
        chk("w0 mem[0x100]", mem1.exists(32'h100) ? {16'h0, mem1[32'h100]} : 32'hFFFF_FFFF, 32'hABCD);

        repeat (3) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
